// File: rtl/irq_source_ctrl.sv
// -----------------------------------------------------------------------------
// irq_source_ctrl
//   Interrupt front-end for RV32core's single-wire `interrupter` input.
//   Level sources are rising-edge detected into pending bits. Pending bits are
//   then filtered by an enable mask and arbitrated with fixed priority (lowest
//   index wins). One request is presented at a time. The request is held until
//   the core acknowledges the trap. No further request is raised until the core
//   reports handler completion (mret).
//
// Ports
//   clk          in   1        core clock, rising edge
//   rst          in   1        synchronous reset, active-high
//   src          in   NUM_SRC  level interrupt sources (same clock domain)
//   en_we        in   1        enable-mask write strobe
//   en_wdata     in   NUM_SRC  new enable mask
//   irq_ack      in   1        core took the trap for the current request
//   irq_done     in   1        core executed mret for the current handler
//   interrupter  out  1        interrupt request to the core
//   irq_id       out  ID_W     index of the source being requested/serviced
//   pending      out  NUM_SRC  pending bits (unmasked view)
//   busy         out  1        high while a request is outstanding or in service
// -----------------------------------------------------------------------------
module irq_source_ctrl #(
    parameter int                   NUM_SRC  = 8,
    parameter int                   ID_W     = 3,
    parameter logic [NUM_SRC-1:0]   EN_RESET = {NUM_SRC{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               interrupter,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Lowest set index of a vector; zero when the vector is empty.
    function automatic logic [ID_W-1:0] lowest_index(input logic [NUM_SRC-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = {ID_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot decode of a source index.
    function automatic logic [NUM_SRC-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NUM_SRC-1:0] oh;
        oh = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            oh[i] = (ID_W'(i) == id);
        end
        return oh;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [NUM_SRC-1:0] src_q_r;
    logic [NUM_SRC-1:0] enable_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] pending_next_s;
    logic [NUM_SRC-1:0] edge_s;
    logic [NUM_SRC-1:0] req_s;
    logic [NUM_SRC-1:0] clr_mask_s;
    logic [ID_W-1:0]    irq_id_r;
    logic               latch_id_s;
    logic               ack_clr_s;
    logic               interrupter_r;
    logic               busy_r;

    assign edge_s = src & ~src_q_r;
    assign req_s  = pending_r & enable_r;

    // Next-state logic: decides transitions, id latching and the ack-driven pending clear.
    always_comb begin
        state_next_s = state_r;
        latch_id_s   = 1'b0;
        ack_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req_s) begin
                    state_next_s = ST_REQ;
                    latch_id_s   = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // irq_done is deliberately ignored until the trap has been taken.
                if (irq_ack) begin
                    state_next_s = ST_SERVICE;
                    ack_clr_s    = 1'b1;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (irq_done) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SERVICE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Pending update: the acknowledged bit is cleared, but a new edge on it in the same cycle wins.
    always_comb begin
        clr_mask_s = {NUM_SRC{1'b0}};
        if (ack_clr_s) begin
            clr_mask_s = id_onehot(irq_id_r);
        end else begin
            clr_mask_s = {NUM_SRC{1'b0}};
        end
        pending_next_s = (pending_r & ~clr_mask_s) | edge_s;
    end

    // State, pending, mask and registered output updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            src_q_r       <= {NUM_SRC{1'b0}};
            enable_r      <= EN_RESET;
            pending_r     <= {NUM_SRC{1'b0}};
            irq_id_r      <= {ID_W{1'b0}};
            interrupter_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            src_q_r   <= src;
            pending_r <= pending_next_s;
            if (en_we) begin
                enable_r <= en_wdata;
            end else begin
                enable_r <= enable_r;
            end
            if (latch_id_s) begin
                irq_id_r <= lowest_index(req_s);
            end else begin
                irq_id_r <= irq_id_r;
            end
            interrupter_r <= (state_next_s == ST_REQ);
            busy_r        <= (state_next_s != ST_IDLE);
        end
    end

    assign interrupter = interrupter_r;
    assign irq_id      = irq_id_r;
    assign pending     = pending_r;
    assign busy        = busy_r;

endmodule
